alu_control_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/cu_dff.sv | 16 +
 rtl/alu_control_unit.sv | 136 +++++++++++++
 tb/tb_alu_control_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state-code definitions for the 16-bit ALU control unit and its datapath.
// State codes are the 5-bit binary index of each sequencer state S0..S22.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_RSR = 4'd7;
    localparam logic [3:0] OP_RSL = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9;
    localparam logic [3:0] OP_OR  = 4'd10;
    localparam logic [3:0] OP_XOR = 4'd11;
    localparam logic [3:0] OP_NOT = 4'd12;
    localparam logic [3:0] OP_CMP = 4'd13;
    localparam logic [3:0] OP_TST = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam logic [4:0] S0  = 5'd0;
    localparam logic [4:0] S1  = 5'd1;
    localparam logic [4:0] S2  = 5'd2;
    localparam logic [4:0] S3  = 5'd3;
    localparam logic [4:0] S4  = 5'd4;
    localparam logic [4:0] S5  = 5'd5;
    localparam logic [4:0] S6  = 5'd6;
    localparam logic [4:0] S7  = 5'd7;
    localparam logic [4:0] S8  = 5'd8;
    localparam logic [4:0] S9  = 5'd9;
    localparam logic [4:0] S10 = 5'd10;
    localparam logic [4:0] S11 = 5'd11;
    localparam logic [4:0] S12 = 5'd12;
    localparam logic [4:0] S13 = 5'd13;
    localparam logic [4:0] S14 = 5'd14;
    localparam logic [4:0] S15 = 5'd15;
    localparam logic [4:0] S16 = 5'd16;
    localparam logic [4:0] S17 = 5'd17;
    localparam logic [4:0] S18 = 5'd18;
    localparam logic [4:0] S19 = 5'd19;
    localparam logic [4:0] S20 = 5'd20;
    localparam logic [4:0] S21 = 5'd21;
    localparam logic [4:0] S22 = 5'd22;

    // Shift/rotate opcodes each own one working state; anything else falls back to idle.
    function automatic logic [4:0] shiftState(input logic [3:0] op);
        logic [4:0] st;
        st = S0;
        case (op)
            OP_LSR:  st = S15;
            OP_LSL:  st = S16;
            OP_RSR:  st = S17;
            OP_RSL:  st = S18;
            default: st = S0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cu_dff.sv
// One bit of the control-unit state register, cleared asynchronously while rst_b is low.
module cu_dff (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            q <= 1'b0;
        else
            q <= d;
    end

endmodule

// File: rtl/alu_control_unit.sv
// Moore sequencer for the 16-bit ALU datapath: decodes the state into 19 one-per-state
// strobes and a one-cycle finish pulse.
module alu_control_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic [3:0]  s,
    input  logic        start,
    input  logic        q0,
    input  logic        q_1,
    input  logic        a_16,
    input  logic        cmp_cnt_m4,
    input  logic [3:0]  cnt,
    output logic [18:0] c,
    output logic        finish
);

    logic [4:0] w_state;
    logic [4:0] w_nextState;
    logic       w_isDivMod;
    logic       w_lastIter;

    assign w_isDivMod = (s == OP_DIV) || (s == OP_MOD);
    assign w_lastIter = (cnt == 4'd15);

    cu_dff f0 (.clk(clk), .rst_b(rst_b), .d(w_nextState[0]), .q(w_state[0]));
    cu_dff f1 (.clk(clk), .rst_b(rst_b), .d(w_nextState[1]), .q(w_state[1]));
    cu_dff f2 (.clk(clk), .rst_b(rst_b), .d(w_nextState[2]), .q(w_state[2]));
    cu_dff f3 (.clk(clk), .rst_b(rst_b), .d(w_nextState[3]), .q(w_state[3]));
    cu_dff f4 (.clk(clk), .rst_b(rst_b), .d(w_nextState[4]), .q(w_state[4]));

    // S4/S5/S8 are shared by several operations, so their successor depends on the opcode.
    always_comb begin
        w_nextState = S0;
        case (w_state)
            S0:  w_nextState = start ? S1 : S0;
            S1:  w_nextState = S2;
            S2: begin
                case (s)
                    OP_ADD:                  w_nextState = S4;
                    OP_SUB:                  w_nextState = S5;
                    OP_MUL:                  w_nextState = S9;
                    OP_DIV, OP_MOD:          w_nextState = S11;
                    OP_LSR, OP_LSL,
                    OP_RSR, OP_RSL:          w_nextState = shiftState(s);
                    OP_AND, OP_TST:          w_nextState = S19;
                    OP_OR:                   w_nextState = S20;
                    OP_XOR:                  w_nextState = S21;
                    OP_NOT:                  w_nextState = S22;
                    OP_CMP:                  w_nextState = S3;
                    default:                 w_nextState = S10;
                endcase
            end
            S3:  w_nextState = S5;
            S4:  w_nextState = (s == OP_MUL) ? S7 : (w_isDivMod ? S12 : S6);
            S5: begin
                if (s == OP_CMP)
                    w_nextState = S0;
                else
                    w_nextState = (s == OP_MUL) ? S7 : (w_isDivMod ? S12 : S6);
            end
            S6:  w_nextState = (s == OP_MUL) ? S10 : S0;
            S7:  w_nextState = w_lastIter ? S6 : S8;
            S8: begin
                if (s == OP_MUL)
                    w_nextState = S9;
                else if (w_isDivMod)
                    w_nextState = S11;
                else
                    w_nextState = cmp_cnt_m4 ? S10 : shiftState(s);
            end
            S9: begin
                case ({q0, q_1})
                    2'b01:   w_nextState = S4;
                    2'b10:   w_nextState = S5;
                    default: w_nextState = S7;
                endcase
            end
            S10: w_nextState = S0;
            S11: w_nextState = a_16 ? S4 : S5;
            S12: w_nextState = w_lastIter ? S14 : S8;
            S14: begin
                if (s == OP_DIV)
                    w_nextState = S10;
                else if (s == OP_MOD)
                    w_nextState = S6;
                else
                    w_nextState = S0;
            end
            S15, S16, S17, S18: w_nextState = S8;
            S19: w_nextState = (s == OP_TST) ? S0 : S6;
            S20, S21, S22:      w_nextState = S6;
            default:            w_nextState = S0;
        endcase
    end

    always_comb begin
        c = 19'd0;
        case (w_state)
            S1:  c[0]  = 1'b1;
            S2:  c[1]  = 1'b1;
            S4:  c[2]  = 1'b1;
            S5:  c[3]  = 1'b1;
            S6:  c[4]  = 1'b1;
            S7:  c[5]  = 1'b1;
            S8:  c[6]  = 1'b1;
            S10: c[7]  = 1'b1;
            S11: c[8]  = 1'b1;
            S12: c[9]  = 1'b1;
            S14: c[10] = 1'b1;
            S15: c[11] = 1'b1;
            S16: c[12] = 1'b1;
            S17: c[13] = 1'b1;
            S18: c[14] = 1'b1;
            S19: c[15] = 1'b1;
            S20: c[16] = 1'b1;
            S21: c[17] = 1'b1;
            S22: c[18] = 1'b1;
            default: c = 19'd0;
        endcase
    end

    // MUL passes through S6 to emit A before Q, so only its final S10 signals completion.
    always_comb begin
        finish = 1'b0;
        case (w_state)
            S10:     finish = 1'b1;
            S6:      finish = (s != OP_MUL);
            S5:      finish = (s == OP_CMP);
            S19:     finish = (s == OP_TST);
            default: finish = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Scoreboard bench for alu_control_unit: each step pushes the expected strobes/finish for
// the state the sequencer should reach, then pops and compares after the clock edge.
module tb_alu_control_unit;

    logic        clk;
    logic        rst_b;
    logic [3:0]  s;
    logic        start;
    logic        q0;
    logic        q_1;
    logic        a_16;
    logic        cmp_cnt_m4;
    logic [3:0]  cnt;
    logic [18:0] c;
    logic        finish;

    typedef struct {
        logic       start;
        logic [3:0] s;
        logic [1:0] qp;
        logic       a16;
        logic       cmp;
        logic [3:0] cnt;
        int         st;
    } step_t;

    typedef struct {
        logic [18:0] c;
        logic        fin;
        int          st;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    // Strobe bit owned by each state index, -1 where the state drives no strobe.
    int bitOf[23] = '{-1, 0, 1, -1, 2, 3, 4, 5, 6, -1, 7, 8, 9, -1, 10,
                      11, 12, 13, 14, 15, 16, 17, 18};

    alu_control_unit dut (
        .clk(clk), .rst_b(rst_b), .s(s), .start(start), .q0(q0), .q_1(q_1),
        .a_16(a_16), .cmp_cnt_m4(cmp_cnt_m4), .cnt(cnt), .c(c), .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] expC(input int st);
        logic [18:0] v;
        v = 19'd0;
        if (bitOf[st] >= 0)
            v[bitOf[st]] = 1'b1;
        return v;
    endfunction

    function automatic logic expFin(input int st, input logic [3:0] op);
        return (st == 10) || (st == 6 && op != 4'd2) ||
               (st == 5 && op == 4'd13) || (st == 19 && op == 4'd14);
    endfunction

    function automatic step_t mk(input logic st_start, input logic [3:0] op,
                                 input logic [1:0] qp, input logic a16,
                                 input logic cmp, input logic [3:0] n, input int st);
        step_t r;
        r.start = st_start; r.s = op; r.qp = qp; r.a16 = a16;
        r.cmp = cmp; r.cnt = n; r.st = st;
        return r;
    endfunction

    // Drives one cycle of inputs, records what should appear after the edge, then clocks.
    task automatic applyStimulus(input step_t stp);
        exp_t e;
        start = stp.start; s = stp.s; {q0, q_1} = stp.qp;
        a_16 = stp.a16; cmp_cnt_m4 = stp.cmp; cnt = stp.cnt;
        e.c = expC(stp.st);
        e.fin = expFin(stp.st, stp.s);
        e.st = stp.st;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        start = 1'b0; s = 4'd0; q0 = 1'b0; q_1 = 1'b0;
        a_16 = 1'b0; cmp_cnt_m4 = 1'b0; cnt = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (c !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_c: got %h expected %h", c, 19'd0);
        end
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_finish: got %b expected 0", finish);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_sub();
        step_t seq[$];
        exp_t  e;
        for (int op = 0; op < 2; op++) begin
            seq.push_back(mk(1, 4'(op), 0, 0, 0, 0, 1));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 2));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, op == 0 ? 4 : 5));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 6));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 0));
        end
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            e = scoreboard.pop_front();
            checks++;
            if (c !== e.c || finish !== e.fin) begin
                errors++;
                $display("[TB] FAIL add_sub step %0d (S%0d): got c=%h fin=%b expected c=%h fin=%b",
                         i, e.st, c, finish, e.c, e.fin);
            end
        end
    endtask

    task automatic test_mul();
        step_t seq[$];
        exp_t  e;
        seq.push_back(mk(1, 2, 2'b00, 0, 0, 0, 1));
        seq.push_back(mk(0, 2, 2'b00, 0, 0, 0, 2));
        seq.push_back(mk(0, 2, 2'b00, 0, 0, 0, 9));
        seq.push_back(mk(0, 2, 2'b11, 0, 0, 0, 7));
        seq.push_back(mk(0, 2, 2'b11, 0, 0, 0, 8));
        seq.push_back(mk(0, 2, 2'b11, 0, 0, 1, 9));
        seq.push_back(mk(0, 2, 2'b10, 0, 0, 1, 5));
        seq.push_back(mk(0, 2, 2'b10, 0, 0, 1, 7));
        seq.push_back(mk(0, 2, 2'b10, 0, 0, 1, 8));
        seq.push_back(mk(0, 2, 2'b10, 0, 0, 2, 9));
        seq.push_back(mk(0, 2, 2'b01, 0, 0, 2, 4));
        seq.push_back(mk(0, 2, 2'b01, 0, 0, 15, 7));
        seq.push_back(mk(0, 2, 2'b01, 0, 0, 15, 6));
        seq.push_back(mk(0, 2, 2'b01, 0, 0, 15, 10));
        seq.push_back(mk(0, 2, 2'b01, 0, 0, 15, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            e = scoreboard.pop_front();
            checks++;
            if (c !== e.c || finish !== e.fin) begin
                errors++;
                $display("[TB] FAIL mul step %0d (S%0d): got c=%h fin=%b expected c=%h fin=%b",
                         i, e.st, c, finish, e.c, e.fin);
            end
        end
    endtask

    task automatic test_div_mod();
        step_t seq[$];
        exp_t  e;
        for (int op = 3; op < 5; op++) begin
            seq.push_back(mk(1, 4'(op), 0, 0, 0, 0, 1));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 2));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 11));
            seq.push_back(mk(0, 4'(op), 0, 1, 0, 0, 4));
            seq.push_back(mk(0, 4'(op), 0, 1, 0, 5, 12));
            seq.push_back(mk(0, 4'(op), 0, 1, 0, 5, 8));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 6, 11));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 6, 5));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 15, 12));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 15, 14));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 15, op == 3 ? 10 : 6));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 15, 0));
        end
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            e = scoreboard.pop_front();
            checks++;
            if (c !== e.c || finish !== e.fin) begin
                errors++;
                $display("[TB] FAIL div_mod step %0d (S%0d): got c=%h fin=%b expected c=%h fin=%b",
                         i, e.st, c, finish, e.c, e.fin);
            end
        end
    endtask

    task automatic test_shift();
        step_t seq[$];
        exp_t  e;
        int    shiftSt[4] = '{15, 16, 17, 18};
        for (int k = 0; k < 4; k++) begin
            seq.push_back(mk(1, 4'(5 + k), 0, 0, 0, 0, 1));
            seq.push_back(mk(0, 4'(5 + k), 0, 0, 0, 0, 2));
            seq.push_back(mk(0, 4'(5 + k), 0, 0, 0, 0, shiftSt[k]));
            seq.push_back(mk(0, 4'(5 + k), 0, 0, 0, 0, 8));
            seq.push_back(mk(0, 4'(5 + k), 0, 0, 0, 0, shiftSt[k]));
            seq.push_back(mk(0, 4'(5 + k), 0, 0, 0, 0, 8));
            seq.push_back(mk(0, 4'(5 + k), 0, 0, 1, 0, 10));
            seq.push_back(mk(0, 4'(5 + k), 0, 0, 0, 0, 0));
        end
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            e = scoreboard.pop_front();
            checks++;
            if (c !== e.c || finish !== e.fin) begin
                errors++;
                $display("[TB] FAIL shift step %0d (S%0d): got c=%h fin=%b expected c=%h fin=%b",
                         i, e.st, c, finish, e.c, e.fin);
            end
        end
    endtask

    task automatic test_logic_cmp_tst();
        step_t seq[$];
        exp_t  e;
        for (int op = 9; op < 13; op++) begin
            seq.push_back(mk(1, 4'(op), 0, 0, 0, 0, 1));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 2));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 19 + op - 9));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 6));
            seq.push_back(mk(0, 4'(op), 0, 0, 0, 0, 0));
        end
        seq.push_back(mk(1, 13, 0, 0, 0, 0, 1));
        seq.push_back(mk(0, 13, 0, 0, 0, 0, 2));
        seq.push_back(mk(0, 13, 0, 0, 0, 0, 3));
        seq.push_back(mk(0, 13, 0, 0, 0, 0, 5));
        seq.push_back(mk(0, 13, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 14, 0, 0, 0, 0, 1));
        seq.push_back(mk(0, 14, 0, 0, 0, 0, 2));
        seq.push_back(mk(0, 14, 0, 0, 0, 0, 19));
        seq.push_back(mk(0, 14, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 15, 0, 0, 0, 0, 1));
        seq.push_back(mk(0, 15, 0, 0, 0, 0, 2));
        seq.push_back(mk(0, 15, 0, 0, 0, 0, 10));
        seq.push_back(mk(0, 15, 0, 0, 0, 0, 0));
        seq.push_back(mk(0, 15, 0, 0, 0, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            e = scoreboard.pop_front();
            checks++;
            if (c !== e.c || finish !== e.fin) begin
                errors++;
                $display("[TB] FAIL logic_cmp_tst step %0d (S%0d): got c=%h fin=%b expected c=%h fin=%b",
                         i, e.st, c, finish, e.c, e.fin);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t seq[$];
        exp_t  e;
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 2));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 4));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 6));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 4));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 6));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            e = scoreboard.pop_front();
            checks++;
            if (c !== e.c || finish !== e.fin) begin
                errors++;
                $display("[TB] FAIL back_to_back step %0d (S%0d): got c=%h fin=%b expected c=%h fin=%b",
                         i, e.st, c, finish, e.c, e.fin);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        step_t seq[$];
        exp_t  e;
        seq.push_back(mk(1, 2, 2'b00, 0, 0, 0, 1));
        seq.push_back(mk(0, 2, 2'b00, 0, 0, 0, 2));
        seq.push_back(mk(0, 2, 2'b00, 0, 0, 0, 9));
        seq.push_back(mk(0, 2, 2'b00, 0, 0, 3, 7));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            e = scoreboard.pop_front();
            checks++;
            if (c !== e.c || finish !== e.fin) begin
                errors++;
                $display("[TB] FAIL reset_mid_op step %0d (S%0d): got c=%h fin=%b expected c=%h fin=%b",
                         i, e.st, c, finish, e.c, e.fin);
            end
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (c !== 19'd0 || finish !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_mid_op: got c=%h fin=%b expected c=%h fin=0",
                     c, finish, 19'd0);
        end
        @(negedge clk);
        rst_b = 1'b1;
        applyStimulus(mk(0, 2, 2'b00, 0, 0, 15, 0));
        e = scoreboard.pop_front();
        checks++;
        if (c !== e.c || finish !== e.fin) begin
            errors++;
            $display("[TB] FAIL after_reset_idle: got c=%h fin=%b expected c=%h fin=%b",
                     c, finish, e.c, e.fin);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div_mod();
        test_shift();
        test_logic_cmp_tst();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
